cache_mem_arbiter: RTL and testbench



---
 rtl/cache_mem_arbiter_if.sv | 34 +++
 rtl/cache_mem_arbiter.sv | 112 +++++++++++
 tb/tb_cache_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the cache fill paths, the arbiter and the RAM port.
// slave = arbiter view, master = cache/RAM side view.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;
  logic              ram_ren;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;
  logic [DATA_W-1:0] ram_load;
  logic              ram_ready;
  logic              arb_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
    output iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_store, arb_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
    input  iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_store, arb_err
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port between icache fill and dcache fill/writeback.
// Optional macro ARB_FAIR_EN: alternate grants when both caches request.
module cache_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input logic               CLK,
  input logic               nRST,
  cache_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic [7:0]        cnt;
`ifdef ARB_FAIR_EN
  logic              last_d;
`endif

  logic              i_req, d_req, held, expired;
  logic              ren_c, wen_c, iwait_c, dwait_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] store_c, iload_c, dload_c;

  assign i_req   = bus.iREN;
  assign d_req   = bus.dREN | bus.dWEN;
  assign held    = (state == IGNT) ? i_req : (state == DGNT) ? d_req : 1'b0;
  assign expired = held && !bus.ram_ready && (cnt == TO_LAST);

  // Outputs decode from the registered state so the wait release lands in
  // the same cycle as ram_ready and strobes drop with the async reset.
  always_comb begin
    ren_c   = 1'b0;
    wen_c   = 1'b0;
    iwait_c = 1'b1;
    dwait_c = 1'b1;
    addr_c  = '0;
    store_c = '0;
    iload_c = '0;
    dload_c = '0;
    case (state)
      IGNT: begin
        ren_c  = 1'b1;
        addr_c = bus.iaddr;
        if (i_req && bus.ram_ready) begin
          iwait_c = 1'b0;
          iload_c = bus.ram_load;
        end
      end
      DGNT: begin
        wen_c   = bus.dWEN;
        ren_c   = bus.dREN & ~bus.dWEN;
        addr_c  = bus.daddr;
        store_c = bus.dstore;
        if (d_req && bus.ram_ready) begin
          dwait_c = 1'b0;
          if (!bus.dWEN) dload_c = bus.ram_load;
        end
      end
      default: ;
    endcase
  end

  assign bus.ram_ren   = ren_c;
  assign bus.ram_wen   = wen_c;
  assign bus.ram_addr  = addr_c;
  assign bus.ram_store = store_c;
  assign bus.iwait     = iwait_c;
  assign bus.dwait     = dwait_c;
  assign bus.iload     = iload_c;
  assign bus.dload     = dload_c;
  assign bus.arb_err   = expired;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
`ifdef ARB_FAIR_EN
      last_d <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
`ifdef ARB_FAIR_EN
          if (d_req && (!i_req || !last_d)) state <= DGNT;
          else if (i_req)                   state <= IGNT;
`else
          if (d_req)      state <= DGNT;
          else if (i_req) state <= IGNT;
`endif
        end
        IGNT, DGNT: begin
          if (!held || bus.ram_ready || expired) begin
            state <= IDLE;
`ifdef ARB_FAIR_EN
            // Only a real completion moves the fairness pointer.
            if (held && bus.ram_ready) last_d <= (state == DGNT);
`endif
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_cache_mem_arbiter;

  localparam int TO = 8;

  logic CLK = 1'b0;
  logic nRST;
  int   checks = 0;
  int   errors = 0;

  cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Reference model: who owns the RAM, how many grant cycles so far,
  // and which side last completed (1 = I, 2 = D).
  int owner = 0;
  int age   = 0;
  int last  = 2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_chk();
    logic        e_ren, e_wen, e_iw, e_dw, e_err, hold;
    logic [31:0] e_addr, e_st, e_il, e_dl;
    e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1; e_err = 0;
    e_addr = 0; e_st = 0; e_il = 0; e_dl = 0; hold = 0;
    if (owner == 1) begin
      hold = bus.iREN;
      e_ren = 1; e_addr = bus.iaddr;
      if (hold && bus.ram_ready) begin e_iw = 0; e_il = bus.ram_load; end
    end else if (owner == 2) begin
      hold = bus.dREN | bus.dWEN;
      e_wen = bus.dWEN;
      e_ren = bus.dREN && !bus.dWEN;
      e_addr = bus.daddr; e_st = bus.dstore;
      if (hold && bus.ram_ready) begin
        e_dw = 0;
        e_dl = bus.dWEN ? 32'h0 : bus.ram_load;
      end
    end
    if (owner != 0 && hold && !bus.ram_ready && age == TO) e_err = 1;
    chk("m_ram_ren",   bus.ram_ren,   e_ren);
    chk("m_ram_wen",   bus.ram_wen,   e_wen);
    chk("m_ram_addr",  bus.ram_addr,  e_addr);
    chk("m_ram_store", bus.ram_store, e_st);
    chk("m_iwait",     bus.iwait,     e_iw);
    chk("m_dwait",     bus.dwait,     e_dw);
    chk("m_iload",     bus.iload,     e_il);
    chk("m_dload",     bus.dload,     e_dl);
    chk("m_arb_err",   bus.arb_err,   e_err);
  endtask

  task automatic model_step();
    logic hi, hd, hold;
    hi = bus.iREN;
    hd = bus.dREN | bus.dWEN;
    if (owner == 0) begin
      age = 1;
`ifdef ARB_FAIR_EN
      if (hi && hd)   owner = (last == 2) ? 1 : 2;
      else if (hd)    owner = 2;
      else if (hi)    owner = 1;
`else
      if (hd)         owner = 2;
      else if (hi)    owner = 1;
`endif
    end else begin
      hold = (owner == 1) ? hi : hd;
      if (!hold)                owner = 0;
      else if (bus.ram_ready) begin last = owner; owner = 0; end
      else if (age == TO)       owner = 0;
      else                      age++;
    end
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic finish_cycle();
    model_chk();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic cycle();
    sample();
    finish_cycle();
  endtask

  task automatic idle_inputs();
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0; bus.ram_ready = 0; bus.ram_load = 0;
    bus.iaddr = 32'h40; bus.daddr = 32'h80; bus.dstore = 32'h1234;
  endtask

  typedef struct {
    logic        iren, dren, dwen, rdy;
    logic [31:0] load;
    logic        ren, wen;
    logic [31:0] addr, st;
    logic        iw, dw;
    logic [31:0] il, dl;
  } vec_t;

  vec_t vt[10];
  int   ord[4];

  initial begin
    // I read with ready two cycles after strobe, then D write racing an I read.
    vt[0] = '{1, 0, 0, 0, 32'h0,        0, 0, 32'h0,  32'h0,    1, 1, 32'h0,        32'h0};
    vt[1] = '{1, 0, 0, 0, 32'h0,        1, 0, 32'h40, 32'h0,    1, 1, 32'h0,        32'h0};
    vt[2] = '{1, 0, 0, 0, 32'h0,        1, 0, 32'h40, 32'h0,    1, 1, 32'h0,        32'h0};
    vt[3] = '{1, 0, 0, 1, 32'hDEADBEEF, 1, 0, 32'h40, 32'h0,    0, 1, 32'hDEADBEEF, 32'h0};
    vt[4] = '{0, 0, 0, 0, 32'h0,        0, 0, 32'h0,  32'h0,    1, 1, 32'h0,        32'h0};
    vt[5] = '{1, 0, 1, 0, 32'h0,        0, 0, 32'h0,  32'h0,    1, 1, 32'h0,        32'h0};
    vt[6] = '{1, 0, 1, 1, 32'hCAFE0000, 0, 1, 32'h80, 32'h1234, 1, 0, 32'h0,        32'h0};
    vt[7] = '{1, 0, 0, 0, 32'h0,        0, 0, 32'h0,  32'h0,    1, 1, 32'h0,        32'h0};
    vt[8] = '{1, 0, 0, 1, 32'h55,       1, 0, 32'h40, 32'h0,    0, 1, 32'h55,       32'h0};
    vt[9] = '{0, 0, 0, 0, 32'h0,        0, 0, 32'h0,  32'h0,    1, 1, 32'h0,        32'h0};

    nRST = 0;
    idle_inputs();
    owner = 0; last = 2;
    @(posedge CLK);
    sample();
    model_chk();
    chk("rst_ram_ren", bus.ram_ren, 1'b0);
    chk("rst_iwait",   bus.iwait,   1'b1);
    chk("rst_dwait",   bus.dwait,   1'b1);
    chk("rst_arb_err", bus.arb_err, 1'b0);
    @(posedge CLK);
    #1 nRST = 1;
    cycle();

    for (int i = 0; i < 10; i++) begin
      bus.iREN = vt[i].iren; bus.dREN = vt[i].dren; bus.dWEN = vt[i].dwen;
      bus.ram_ready = vt[i].rdy; bus.ram_load = vt[i].load;
      sample();
      chk($sformatf("v%0d_ram_ren", i),   bus.ram_ren,   vt[i].ren);
      chk($sformatf("v%0d_ram_wen", i),   bus.ram_wen,   vt[i].wen);
      chk($sformatf("v%0d_ram_addr", i),  bus.ram_addr,  vt[i].addr);
      chk($sformatf("v%0d_ram_store", i), bus.ram_store, vt[i].st);
      chk($sformatf("v%0d_iwait", i),     bus.iwait,     vt[i].iw);
      chk($sformatf("v%0d_dwait", i),     bus.dwait,     vt[i].dw);
      chk($sformatf("v%0d_iload", i),     bus.iload,     vt[i].il);
      chk($sformatf("v%0d_dload", i),     bus.dload,     vt[i].dl);
      finish_cycle();
    end

    // Timeout: RAM never ready, error in the 8th grant cycle, then re-grant.
    idle_inputs();
    bus.dREN = 1;
    cycle();
    for (int g = 1; g <= TO; g++) begin
      sample();
      chk($sformatf("to_err_g%0d", g), bus.arb_err, (g == TO));
      chk($sformatf("to_dwait_g%0d", g), bus.dwait, 1'b1);
      chk($sformatf("to_ren_g%0d", g), bus.ram_ren, 1'b1);
      finish_cycle();
    end
    sample();
    chk("to_idle_ren", bus.ram_ren, 1'b0);
    chk("to_idle_err", bus.arb_err, 1'b0);
    finish_cycle();
    sample();
    chk("to_regrant_ren", bus.ram_ren, 1'b1);
    chk("to_regrant_dwait", bus.dwait, 1'b1);
    finish_cycle();
    bus.dREN = 0;
    cycle();
    cycle();

    // Abort: iREN dropped while granted; ready in and after the abort cycle.
    bus.iREN = 1;
    cycle();
    sample();
    chk("ab_grant_ren", bus.ram_ren, 1'b1);
    finish_cycle();
    bus.iREN = 0; bus.ram_ready = 1; bus.ram_load = 32'h77;
    sample();
    chk("ab_cycle_ren", bus.ram_ren, 1'b1);
    chk("ab_cycle_iwait", bus.iwait, 1'b1);
    chk("ab_cycle_iload", bus.iload, 32'h0);
    finish_cycle();
    sample();
    chk("ab_next_ren", bus.ram_ren, 1'b0);
    chk("ab_next_iwait", bus.iwait, 1'b1);
    chk("ab_next_dwait", bus.dwait, 1'b1);
    finish_cycle();
    idle_inputs();
    cycle();

    // Grant order with both requests held; an I completion goes first.
`ifdef ARB_FAIR_EN
    ord = '{2, 1, 2, 1};
`else
    ord = '{2, 2, 2, 2};
`endif
    bus.iREN = 1; bus.ram_ready = 1; bus.ram_load = 32'h11;
    cycle();
    cycle();
    bus.dREN = 1;
    for (int k = 0; k < 8; k++) begin
      sample();
      if (k % 2 == 1)
        chk($sformatf("order_t%0d_addr", k / 2), bus.ram_addr,
            (ord[k / 2] == 2) ? 32'h80 : 32'h40);
      finish_cycle();
    end
    idle_inputs();
    cycle();

    // Asynchronous reset in the middle of a D write grant.
    bus.dWEN = 1;
    cycle();
    sample();
    chk("rstg_wen_before", bus.ram_wen, 1'b1);
    model_chk();
    model_step();
    #2 nRST = 0;
    #1;
    chk("rstg_wen_async", bus.ram_wen, 1'b0);
    chk("rstg_ren_async", bus.ram_ren, 1'b0);
    chk("rstg_dwait_async", bus.dwait, 1'b1);
    owner = 0; last = 2;
    @(posedge CLK);
    #1;
    bus.dWEN = 0;
    nRST = 1;
    sample();
    chk("rstg_after_addr", bus.ram_addr, 32'h0);
    chk("rstg_after_store", bus.ram_store, 32'h0);
    finish_cycle();

    // Randomized traffic with sticky requests.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) bus.iREN = ~bus.iREN;
      if ($urandom_range(0, 7) == 0) bus.dREN = ~bus.dREN;
      if ($urandom_range(0, 9) == 0) bus.dWEN = ~bus.dWEN;
      bus.iaddr     = $urandom;
      bus.daddr     = $urandom;
      bus.dstore    = $urandom;
      bus.ram_load  = $urandom;
      bus.ram_ready = ($urandom_range(0, 4) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
